// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// master: stream producer / memory side, slave: the loader itself.
interface imem_loader_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;

    modport master (
        output in_data, in_valid,
        input  in_ready,
        input  imem_we, imem_waddr, imem_wdata
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready,
        output imem_we, imem_waddr, imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader. Consumes a length-prefixed big-endian
// byte stream, assembles 32-bit words, writes them one per cycle into the
// instruction memory and keeps the CPU in reset until the image is complete.
module imem_loader #(
    parameter int unsigned DEPTH     = 128,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    imem_loader_if.slave  bus,
    input  logic          reload,
    output logic          cpu_rst_n,
    output logic          done,
    output logic          error,
    output logic [15:0]   words_written
);

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        DATA,
        WRITE,
        DONE,
        ERR
    } state_t;

    state_t      state;
    logic [7:0]  cnt_hi;
    logic [15:0] remaining;
    logic [1:0]  byte_idx;

    logic        xfer;
    logic [15:0] hdr_n;

    assign xfer  = bus.in_valid && bus.in_ready;
    // full word count as soon as the low header byte is on the bus
    assign hdr_n = {cnt_hi, bus.in_data};

    // Loader FSM; every output is a register updated alongside the state so
    // cpu_rst_n and imem_we never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= HDR_HI;
            cnt_hi         <= 8'h00;
            remaining      <= 16'h0000;
            byte_idx       <= 2'd0;
            bus.in_ready   <= 1'b0;
            bus.imem_we    <= 1'b0;
            bus.imem_waddr <= BASE_ADDR;
            bus.imem_wdata <= 32'h0000_0000;
            cpu_rst_n      <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            words_written  <= 16'h0000;
        end else begin
            case (state)
                HDR_HI: begin
                    // in_ready comes up one cycle after reset release
                    bus.in_ready <= 1'b1;
                    if (xfer) begin
                        cnt_hi <= bus.in_data;
                        state  <= HDR_LO;
                    end
                end
                HDR_LO: begin
                    if (xfer) begin
                        if (hdr_n == 16'h0000) begin
                            state        <= DONE;
                            bus.in_ready <= 1'b0;
                            done         <= 1'b1;
                            cpu_rst_n    <= 1'b1;
                        end else if (hdr_n > 16'(DEPTH)) begin
                            state        <= ERR;
                            bus.in_ready <= 1'b0;
                            error        <= 1'b1;
                        end else begin
                            remaining <= hdr_n;
                            byte_idx  <= 2'd0;
                            state     <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        bus.imem_wdata <= {bus.imem_wdata[23:0], bus.in_data};
                        byte_idx       <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            state        <= WRITE;
                            bus.in_ready <= 1'b0;
                            bus.imem_we  <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    bus.imem_we    <= 1'b0;
                    bus.imem_waddr <= bus.imem_waddr + 32'd4;
                    remaining      <= remaining - 16'd1;
                    words_written  <= words_written + 16'd1;
                    byte_idx       <= 2'd0;
                    if (remaining == 16'd1) begin
                        // last word is in memory now; release the core
                        state     <= DONE;
                        done      <= 1'b1;
                        cpu_rst_n <= 1'b1;
                    end else begin
                        state        <= DATA;
                        bus.in_ready <= 1'b1;
                    end
                end
                DONE, ERR: begin
                    if (reload) begin
                        state          <= HDR_HI;
                        bus.in_ready   <= 1'b1;
                        bus.imem_waddr <= BASE_ADDR;
                        cpu_rst_n      <= 1'b0;
                        done           <= 1'b0;
                        error          <= 1'b0;
                        words_written  <= 16'h0000;
                    end
                end
                default: begin
                    state        <= HDR_HI;
                    bus.in_ready <= 1'b0;
                    bus.imem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader. A stream-level model turns each byte image
// into the list of writes it must produce; a per-cycle monitor checks the
// selected DUT against that list and the state-independent output rules.
module tb_imem_loader;

    localparam int DEPTH = 128;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic       clk;
    logic       rst_n;
    logic       reload;
    logic       sel;      // 0: dut_a (base 0), 1: dut_b (base 0x100)
    logic [7:0] d_data;
    logic       d_valid;

    imem_loader_if ifa ();
    imem_loader_if ifb ();

    logic        a_crst, a_done, a_err, b_crst, b_done, b_err;
    logic [15:0] a_words, b_words;

    assign ifa.in_data  = d_data;
    assign ifb.in_data  = d_data;
    assign ifa.in_valid = d_valid & ~sel;
    assign ifb.in_valid = d_valid & sel;

    imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(32'h0000_0000)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa), .reload(reload & ~sel),
        .cpu_rst_n(a_crst), .done(a_done), .error(a_err), .words_written(a_words)
    );

    imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(32'h0000_0100)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb), .reload(reload & sel),
        .cpu_rst_n(b_crst), .done(b_done), .error(b_err), .words_written(b_words)
    );

    // outputs of whichever DUT is under test
    logic        s_rdy, s_we, s_crst, s_done, s_err;
    logic [31:0] s_waddr, s_wdata;
    logic [15:0] s_words;

    always_comb begin
        s_rdy   = sel ? ifb.in_ready   : ifa.in_ready;
        s_we    = sel ? ifb.imem_we    : ifa.imem_we;
        s_waddr = sel ? ifb.imem_waddr : ifa.imem_waddr;
        s_wdata = sel ? ifb.imem_wdata : ifa.imem_wdata;
        s_crst  = sel ? b_crst  : a_crst;
        s_done  = sel ? b_done  : a_done;
        s_err   = sel ? b_err   : a_err;
        s_words = sel ? b_words : a_words;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic rst_q;
    always @(posedge clk) rst_q <= rst_n;

    int vecs = 0;
    int miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- model ----------------
    logic [7:0] stim[$];
    wr_t        expq[$];
    wr_t        log_q[$];
    int         wcnt;
    bit         exp_err;
    int         exp_words;

    task automatic set_hdr(input int n);
        logic [15:0] n16;
        n16 = 16'(n);
        stim.delete();
        stim.push_back(n16[15:8]);
        stim.push_back(n16[7:0]);
    endtask

    task automatic add_word(input logic [31:0] w);
        stim.push_back(w[31:24]);
        stim.push_back(w[23:16]);
        stim.push_back(w[15:8]);
        stim.push_back(w[7:0]);
    endtask

    // Expected writes straight from the stream format.
    task automatic model_load(input logic [31:0] base);
        int n;
        wr_t w;
        n = int'({stim[0], stim[1]});
        expq.delete();
        log_q.delete();
        wcnt      = 0;
        exp_err   = (n > DEPTH);
        exp_words = exp_err ? 0 : n;
        for (int i = 0; i < exp_words; i++) begin
            w.a = base + 32'(4 * i);
            w.d = {stim[2+4*i], stim[3+4*i], stim[4+4*i], stim[5+4*i]};
            expq.push_back(w);
        end
    endtask

    // Per-cycle monitor
    initial begin
        wr_t w;
        forever begin
            @(negedge clk);
            if (rst_n && rst_q) begin
                chk("words_written", 32'(s_words), 32'(wcnt));
                chk("in_ready_rule", 32'(s_rdy), 32'(!(s_we || s_done || s_err)));
                chk("cpu_rst_n_rule", 32'(s_crst), 32'(s_done));
                if (s_done) chk("done_pending_writes", 32'(expq.size()), 32'd0);
                if (s_done) chk("done_without_err", 32'(exp_err), 32'd0);
                if (s_err)  chk("error_legal", 32'(exp_err), 32'd1);
                if (s_we) begin
                    if (expq.size() == 0) begin
                        chk("spurious_write_addr", s_waddr, 32'hFFFF_FFFF);
                    end else begin
                        w = expq.pop_front();
                        chk("write_addr", s_waddr, w.a);
                        chk("write_data", s_wdata, w.d);
                        wcnt++;
                    end
                    w.a = s_waddr;
                    w.d = s_wdata;
                    log_q.push_back(w);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        d_valid = 1'b0;
        repeat (n) begin
            d_data = 8'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic r;
        int   t;
        d_data  = b;
        d_valid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            r = s_rdy;
            @(posedge clk);
            #1;
            t++;
        end while (!r && t < 50);
        if (!r) chk("send_timeout", 32'(t), 32'd0);
        d_valid = 1'b0;
    endtask

    task automatic send_range(input int first, input int last, input int gap, input int rl_at);
        for (int i = first; i <= last; i++) begin
            if (i == rl_at) begin
                reload = 1'b1;
                @(posedge clk);
                #1;
                reload = 1'b0;
            end
            send_byte(stim[i]);
            if (gap > 0) idle(gap);
        end
    endtask

    task automatic wait_end();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(s_done || s_err) && t < 40);
        if (!(s_done || s_err)) chk("end_timeout", 32'(t), 32'd0);
        chk("final_done",  32'(s_done),  32'(!exp_err));
        chk("final_error", 32'(s_err),   32'(exp_err));
        chk("final_words", 32'(s_words), 32'(exp_words));
        chk("final_queue", 32'(expq.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reload(input logic [31:0] base);
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
        model_load(base);
        @(negedge clk);
        chk("reload_done",  32'(s_done), 32'd0);
        chk("reload_crst",  32'(s_crst), 32'd0);
        chk("reload_error", 32'(s_err),  32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic basic_stim();
        set_hdr(2);
        add_word(32'h2008_0005);
        add_word(32'h2009_0007);
    endtask

    initial begin
        rst_n   = 1'b0;
        reload  = 1'b0;
        sel     = 1'b0;
        d_data  = 8'h00;
        d_valid = 1'b0;
        wcnt    = 0;
        exp_err = 1'b0;
        #1;
        chk("rst_in_ready",  32'(s_rdy),   32'd0);
        chk("rst_we",        32'(s_we),    32'd0);
        chk("rst_waddr",     s_waddr,      32'h0);
        chk("rst_wdata",     s_wdata,      32'h0);
        chk("rst_cpu_rst_n", 32'(s_crst),  32'd0);
        chk("rst_done",      32'(s_done),  32'd0);
        chk("rst_words",     32'(s_words), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // basic load, valid held high
        basic_stim();
        model_load(32'h0);
        send_range(0, stim.size() - 1, 0, -1);
        wait_end();
        chk("basic_nwr",   32'(log_q.size()), 32'd2);
        chk("basic_a0",    log_q[0].a, 32'h0);
        chk("basic_d0",    log_q[0].d, 32'h2008_0005);
        chk("basic_a1",    log_q[1].a, 32'h4);
        chk("basic_d1",    log_q[1].d, 32'h2009_0007);
        chk("basic_crst",  32'(s_crst),  32'd1);
        chk("basic_words", 32'(s_words), 32'd2);

        // same image with in_valid pattern 1,0,0,1,...
        basic_stim();
        do_reload(32'h0);
        send_range(0, stim.size() - 1, 2, -1);
        wait_end();
        chk("gap_d0", log_q[0].d, 32'h2008_0005);
        chk("gap_d1", log_q[1].d, 32'h2009_0007);

        // N=1, reload pulsed mid-word must be ignored
        set_hdr(1);
        add_word(32'hABCD_EF01);
        do_reload(32'h0);
        send_range(0, stim.size() - 1, 0, 4);
        wait_end();
        chk("n1_nwr", 32'(log_q.size()), 32'd1);
        chk("n1_a",   log_q[0].a, 32'h0);
        chk("n1_d",   log_q[0].d, 32'hABCD_EF01);

        // N=0: done straight after the header
        set_hdr(0);
        do_reload(32'h0);
        send_range(0, 1, 0, -1);
        wait_end();
        chk("n0_nwr",  32'(log_q.size()), 32'd0);
        chk("n0_done", 32'(s_done), 32'd1);

        // N=DEPTH: full memory
        set_hdr(128);
        for (int i = 0; i < 128; i++) add_word(32'h1000_0000 + 32'(i) * 32'h0001_0003);
        do_reload(32'h0);
        send_range(0, stim.size() - 1, 0, -1);
        wait_end();
        chk("n128_nwr",   32'(log_q.size()), 32'd128);
        chk("n128_lasta", log_q[127].a, 32'h1FC);
        chk("n128_lastd", log_q[127].d, 32'h1000_0000 + 32'd127 * 32'h0001_0003);

        // N=DEPTH+1: error, core stays in reset
        set_hdr(129);
        do_reload(32'h0);
        send_range(0, 1, 0, -1);
        wait_end();
        idle(3);
        chk("n129_err",  32'(s_err),  32'd1);
        chk("n129_crst", 32'(s_crst), 32'd0);
        chk("n129_rdy",  32'(s_rdy),  32'd0);
        chk("n129_nwr",  32'(log_q.size()), 32'd0);

        // reset after two bytes of the first word
        set_hdr(1);
        add_word(32'hAABB_CCDD);
        do_reload(32'h0);
        send_range(0, 3, 0, -1);
        rst_n = 1'b0;
        #1;
        chk("mrst_rdy",   32'(s_rdy),   32'd0);
        chk("mrst_we",    32'(s_we),    32'd0);
        chk("mrst_waddr", s_waddr,      32'h0);
        chk("mrst_wdata", s_wdata,      32'h0);
        chk("mrst_crst",  32'(s_crst),  32'd0);
        chk("mrst_done",  32'(s_done),  32'd0);
        chk("mrst_err",   32'(s_err),   32'd0);
        chk("mrst_words", 32'(s_words), 32'd0);
        expq.delete();
        wcnt = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("mrst_nwr", 32'(log_q.size()), 32'd0);
        rst_n = 1'b1;
        set_hdr(1);
        add_word(32'h1234_5678);
        model_load(32'h0);
        @(posedge clk);
        #1;
        send_range(0, stim.size() - 1, 0, -1);
        wait_end();
        chk("mrst_a", log_q[0].a, 32'h0);
        chk("mrst_d", log_q[0].d, 32'h1234_5678);

        // non-zero base on the second instance
        set_hdr(3);
        add_word(32'h0000_0111);
        add_word(32'h0000_0222);
        add_word(32'h0000_0333);
        sel = 1'b1;
        model_load(32'h100);
        send_range(0, stim.size() - 1, 1, -1);
        wait_end();
        chk("base_a0", log_q[0].a, 32'h100);
        chk("base_a1", log_q[1].a, 32'h104);
        chk("base_a2", log_q[2].a, 32'h108);
        chk("base_d2", log_q[2].d, 32'h0000_0333);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart to the instruction memory; it fills the memory at boot from a byte stream instead of a preloaded file image.
- Accepts a length-prefixed, big-endian byte stream over a valid/ready handshake and assembles 32-bit words.
- Issues single-cycle word writes to the instruction memory write port.
- Holds the CPU in reset until loading completes.

Parameters:
- DEPTH, 128, number of 32-bit words in instruction memory; maximum legal word count.
- BASE_ADDR, 32'h0000_0000, byte address of the first word written; must be word-aligned.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader can accept a byte this cycle.
- reload  input  1  single-cycle pulse; restarts loading, honoured only in DONE or ERR.
- imem_we  output  1  instruction memory write enable, one cycle per word.
- imem_waddr  output  32  byte address of the write; word-aligned.
- imem_wdata  output  32  instruction word to write.
- cpu_rst_n  output  1  active-low reset to the CPU core; low while loading.
- done  output  1  load finished successfully.
- error  output  1  header word count exceeded DEPTH.
- words_written  output  16  count of words written in the current load.

Behaviour:
- Reset (async, rst_n=0):
  - State = HDR_HI.
  - in_ready=0, imem_we=0, imem_waddr=BASE_ADDR, imem_wdata=0.
  - cpu_rst_n=0, done=0, error=0, words_written=0.
  - Byte index=0, remaining=0.
- Byte transfer: occurs on a rising edge with in_valid=1 and in_ready=1. in_data is ignored otherwise. in_ready does not depend on in_valid.
- Stream format: 2-byte word count N (MSB byte first), then N words of 4 bytes each, MSB byte first. This matches the hex image word order.
- States:
  - HDR_HI: in_ready=1. On transfer, count[15:8] <= byte; go to HDR_LO.
  - HDR_LO: in_ready=1. On transfer, form N.
    - N=0: go to DONE.
    - N>DEPTH: go to ERR.
    - Otherwise: remaining <= N, byte index <= 0; go to DATA.
  - DATA: in_ready=1. Each transfer does wdata <= {wdata[23:0], byte} and increments the byte index. On the 4th byte (index 3), go to WRITE.
  - WRITE: exactly one cycle.
    - in_ready=0, imem_we=1, imem_waddr and imem_wdata stable.
    - At the end of the cycle: imem_waddr += 4, remaining -= 1, words_written += 1, byte index <= 0.
    - Go to DONE if remaining was 1, else DATA.
  - DONE: in_ready=0, imem_we=0, done=1, cpu_rst_n=1. Hold until reload.
  - ERR: in_ready=0, error=1, cpu_rst_n=0. Hold until reload or reset.
- Reload:
  - reload=1 in DONE or ERR returns to HDR_HI on the next edge.
  - Clears done, error and words_written; imem_waddr <= BASE_ADDR; cpu_rst_n <= 0 in the same edge.
  - reload is ignored in all other states.
- Latency:
  - 4th data byte accepted at edge k → imem_we high during cycle k+1.
  - The earliest next byte transfer is at edge k+2.
  - The last word's WRITE cycle is followed by done=1 and cpu_rst_n=1 from the next edge.
- Width and arithmetic:
  - imem_waddr wraps modulo 2^32; this cannot occur with legal N and BASE_ADDR.
  - The N>DEPTH comparison is unsigned over 16 bits.
- cpu_rst_n is registered and glitch-free; it never rises before the final write completes.
- rst_n asserted mid-load aborts immediately to reset values. Partial words are discarded, with no write issued.

Test Plan:
- Basic load: bytes 00 02 | 20 08 00 05 | 20 09 00 07, in_valid held high → two write pulses, each one cycle:
  - addr 0x0, data 0x20080005.
  - addr 0x4, data 0x20090007.
  - Then done=1, cpu_rst_n=1, words_written=2.
- Backpressure/gaps: same stream with in_valid toggled 1,0,0,1,… → identical writes. in_ready is 0 only in WRITE, and no byte is lost or duplicated.
- Boundary counts:
  - N=0 → DONE straight after the header, no imem_we.
  - N=128 → 128 writes, last addr 0x1FC.
  - N=129 → error=1, cpu_rst_n stays 0, in_ready=0, no writes.
- Reload: after a completed N=2 load, pulse reload → cpu_rst_n=0 and done=0 next cycle. A new N=1 stream (00 01 AB CD EF 01) writes 0xABCDEF01 to addr 0x0. reload pulsed during DATA is ignored.
- Mid-load reset: assert rst_n=0 after 2 bytes of word 1 → all outputs return to reset values asynchronously with no write. A full stream after release loads correctly from BASE_ADDR.
- Non-zero base: BASE_ADDR=0x100, N=3 → writes at 0x100, 0x104, 0x108 in stream order.
